pt_rf_arbiter: RTL
==================

PT_RF_ARBITER -- requirements
Module: pt_rf_arbiter

Interface
REQ-001 Parameter N_REQ, default 2: number of requesters sharing one register-file port; legal range 2..16.
REQ-002 Parameter ADDR_W, default 32: register address width.
REQ-003 Parameter DATA_W, default 64: register data width.
REQ-004 Parameter RF_PIPELINING, default 1: cycles from downstream enable to i_rf_rd_data/i_rf_error valid; legal range >=1.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 i_clk  in  1  clock; all state on rising edge.
REQ-007 i_rst_n  in  1  asynchronous active-low reset.
REQ-008 i_req_valid  in  N_REQ  per-requester access request.
REQ-009 i_req_address  in  N_REQ x ADDR_W  per-requester address.
REQ-010 i_req_wr_data  in  N_REQ x DATA_W  per-requester write data.
REQ-011 i_req_write  in  N_REQ  per-requester 1=write, 0=read.
REQ-012 o_req_ready  out  N_REQ  one-hot grant; request transfers when valid and ready are both high.
REQ-013 o_rsp_valid  out  N_REQ  one-hot response strobe to the originating requester.
REQ-014 o_rsp_data  out  DATA_W  response read data, shared by all requesters.
REQ-015 o_rsp_error  out  1  response error, shared by all requesters.
REQ-016 o_rf_address / o_rf_wr_data / o_rf_write / o_rf_enable  out  ADDR_W / DATA_W / 1 / 1  downstream register port.
REQ-017 i_rf_rd_data / i_rf_error  in  DATA_W / 1  downstream response, sampled RF_PIPELINING cycles after enable.
REQ-018 o_idle  out  1  high when no i_req_valid is asserted and no access is in flight.

Function
REQ-019 Round-robin arbitration SHALL grant the lowest-indexed valid requester at or above priority pointer ptr, wrapping from N_REQ-1 to 0.
REQ-020 Grant SHALL be combinational in the request cycle; zero added latency, at most one grant per cycle.
REQ-021 On a grant to index g, ptr SHALL update to (g+1) mod N_REQ at the next edge; with no grant, ptr SHALL hold.
REQ-022 With a grant, o_rf_enable=1 and o_rf_address/o_rf_wr_data/o_rf_write SHALL come from requester g; with no grant, o_rf_enable=0 and o_rf_write=0.
REQ-023 The granted index SHALL be tracked through an RF_PIPELINING-deep valid+index shift pipeline.
REQ-024 o_rsp_valid[g] SHALL pulse for one cycle exactly RF_PIPELINING cycles after the grant; o_rsp_data=i_rf_rd_data and o_rsp_error=i_rf_error in that cycle.
REQ-025 Responses have no backpressure; requesters SHALL accept o_rsp_valid unconditionally.
REQ-026 Back-to-back grants every cycle SHALL be supported; responses return in grant order.
REQ-027 A requester that drops valid before being granted loses no state; the request is simply not issued.
REQ-028 A single continuously valid requester SHALL be granted every cycle.
REQ-029 o_rsp_data/o_rsp_error outside a response cycle are don't-care; o_rsp_valid SHALL be all-zero in those cycles.

Reset
REQ-030 While i_rst_n=0: ptr=0, pipeline valids=0, o_rsp_valid=0, o_rf_enable=0, o_rf_write=0, o_req_ready=0, o_idle=1.
REQ-031 Assertion of reset mid-access SHALL discard in-flight responses; no o_rsp_valid pulse SHALL follow reset release for them.
REQ-032 The first grant after reset release SHALL favour index 0.

Structure
REQ-033 Shared package pt_rf_pkg SHALL hold the rf request struct (address, wr_data, write) and the pending-entry struct (valid, index).
REQ-034 Arbitration SHALL be a sub-module pt_rr_arbiter (N inputs, one-hot grant, pointer update on accept), reusable elsewhere.

Verification
REQ-035 N_REQ=2, RF_PIPELINING=1: both requesters valid for 4 cycles after reset -> grants 0,1,0,1; rsp_valid 1 cycle later to 0,1,0,1.
REQ-036 Requester 1 only, write addr 0x10 data 0xAB -> o_rf_enable=1, o_rf_write=1, address 0x10 same cycle; o_rsp_valid=2'b10 next cycle.
REQ-037 RF_PIPELINING=3, reads from 0 then 1 back-to-back, i_rf_rd_data 0x11 then 0x22 -> rsp_valid[0] with 0x11 at cycle+3, rsp_valid[1] with 0x22 at cycle+4.
REQ-038 N_REQ=4, ptr=3, requesters 0 and 2 valid -> grant 0 (wrap), then 2.
REQ-039 i_rf_error=1 in a response cycle -> o_rsp_error=1 with the correct one-hot o_rsp_valid.
REQ-040 Reset asserted one cycle after a grant with RF_PIPELINING=2 -> no o_rsp_valid after release; o_idle=1; ptr=0.

Source files
------------

// File: rtl/pt_rf_pkg.sv
// rtl/pt_rf_pkg.sv - shared types for the register-file arbiter slice
// Structs are sized for the widest supported port: ADDR_W <= 32, DATA_W <= 64, N_REQ <= 16.
package pt_rf_pkg;

  localparam int RF_ADDR_W = 32;
  localparam int RF_DATA_W = 64;
  localparam int RF_IDX_W  = 4;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] address;
    logic [RF_DATA_W-1:0] wr_data;
    logic                 write;
  } rf_req_t;

  typedef struct packed {
    logic                valid;
    logic [RF_IDX_W-1:0] index;
  } pend_t;

endpackage

// File: rtl/pt_rf_arbiter_if.sv
// rtl/pt_rf_arbiter_if.sv - requester and register-file port bundle for pt_rf_arbiter
interface pt_rf_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);

  logic [N_REQ-1:0]             i_req_valid;
  logic [N_REQ-1:0][ADDR_W-1:0] i_req_address;
  logic [N_REQ-1:0][DATA_W-1:0] i_req_wr_data;
  logic [N_REQ-1:0]             i_req_write;
  logic [N_REQ-1:0]             o_req_ready;
  logic [N_REQ-1:0]             o_rsp_valid;
  logic [DATA_W-1:0]            o_rsp_data;
  logic                         o_rsp_error;
  logic [ADDR_W-1:0]            o_rf_address;
  logic [DATA_W-1:0]            o_rf_wr_data;
  logic                         o_rf_write;
  logic                         o_rf_enable;
  logic [DATA_W-1:0]            i_rf_rd_data;
  logic                         i_rf_error;
  logic                         o_idle;

  modport slave (
    input  i_req_valid, i_req_address, i_req_wr_data, i_req_write,
    input  i_rf_rd_data, i_rf_error,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_error,
    output o_rf_address, o_rf_wr_data, o_rf_write, o_rf_enable, o_idle
  );

  modport master (
    output i_req_valid, i_req_address, i_req_wr_data, i_req_write,
    output i_rf_rd_data, i_rf_error,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_error,
    input  o_rf_address, o_rf_wr_data, o_rf_write, o_rf_enable, o_idle
  );

endinterface

// File: rtl/pt_rr_arbiter.sv
// rtl/pt_rr_arbiter.sv - N-way round-robin arbiter, combinational one-hot grant
// The pointer advances past the granted index only when the grant is accepted.
module pt_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_accept,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_valid
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   w_cand;

  // Scan N candidates starting at the pointer, wrapping modulo N.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_cand        = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(N)) begin
        w_cand = w_cand - (IDX_W+1)'(N);
      end
      if (!o_grant_valid && i_req[w_cand[IDX_W-1:0]]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = w_cand[IDX_W-1:0];
      end
    end
  end

  assign o_grant = o_grant_valid ? (N'(1) << o_grant_idx) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_accept && o_grant_valid) begin
      r_ptr <= (o_grant_idx == IDX_W'(N-1)) ? '0 : o_grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/pt_rf_arbiter.sv
// rtl/pt_rf_arbiter.sv - shares one pipelined register-file port among N_REQ requesters
// Responses are routed back by an RF_PIPELINING-deep valid+index shift pipeline.
module pt_rf_arbiter
  import pt_rf_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 64,
  parameter int RF_PIPELINING = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  pt_rf_arbiter_if.slave  io_rf
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] w_req_eff;
  logic [N_REQ-1:0] w_grant;
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_grant_valid;
  rf_req_t          w_sel;
  pend_t            r_pipe [RF_PIPELINING];
  logic             w_in_flight;
  logic [N_REQ-1:0] w_rsp_onehot;

  // Requests are masked during reset so nothing is granted or reported busy.
  assign w_req_eff = io_rf.i_req_valid & {N_REQ{i_rst_n}};

  pt_rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req         (w_req_eff),
    .i_accept      (w_grant_valid),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  always_comb begin
    w_sel         = '0;
    w_sel.address = RF_ADDR_W'(io_rf.i_req_address[w_grant_idx]);
    w_sel.wr_data = RF_DATA_W'(io_rf.i_req_wr_data[w_grant_idx]);
    w_sel.write   = io_rf.i_req_write[w_grant_idx];
  end

  assign io_rf.o_req_ready  = w_grant;
  assign io_rf.o_rf_enable  = w_grant_valid;
  assign io_rf.o_rf_write   = w_grant_valid & w_sel.write;
  assign io_rf.o_rf_address = w_sel.address[ADDR_W-1:0];
  assign io_rf.o_rf_wr_data = w_sel.wr_data[DATA_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RF_PIPELINING; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0].valid <= w_grant_valid;
      r_pipe[0].index <= RF_IDX_W'(w_grant_idx);
      for (int i = 1; i < RF_PIPELINING; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  always_comb begin
    w_in_flight = 1'b0;
    for (int i = 0; i < RF_PIPELINING; i++) begin
      w_in_flight = w_in_flight | r_pipe[i].valid;
    end
  end

  // The last stage lines up with the cycle the register file presents its answer.
  assign w_rsp_onehot = r_pipe[RF_PIPELINING-1].valid ?
                        (N_REQ'(1) << r_pipe[RF_PIPELINING-1].index) : '0;

  assign io_rf.o_rsp_valid = w_rsp_onehot;
  assign io_rf.o_rsp_data  = io_rf.i_rf_rd_data;
  assign io_rf.o_rsp_error = io_rf.i_rf_error;
  assign io_rf.o_idle      = ~(|w_req_eff) & ~w_in_flight;

endmodule
